// File: rtl/shared_mem_pkg.sv
// Types shared between the per-core memory ports and the four-way shared-memory arbiter.
package shared_mem_pkg;

   localparam int ADDR_W = 17;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       din;
      logic              we;
   } data_in;

   typedef enum logic [1:0] {IDLE, REQ, LAT, DONE} mem_port_state_e;

endpackage

// File: rtl/core_mem_port.sv
// Per-core initiator toward the shared data memory: latches a two-lane access, holds it
// through arbitration stalls, waits out the read latency and returns load data.
// Build option: define CORE_MEM_PORT_STALL_CNT_EN to enable the arbitration stall counter.
module core_mem_port #(
   parameter int READ_LATENCY = 3,
   parameter int ADDR_W       = shared_mem_pkg::ADDR_W
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   req_valid,
   input  logic                   req_u_en,
   input  logic                   req_l_en,
   input  shared_mem_pkg::data_in req_u,
   input  shared_mem_pkg::data_in req_l,
   output logic                   interlock,
   output logic                   rd_valid,
   output logic [31:0]            rd_u,
   output logic [31:0]            rd_l,
   output logic                   mem_req_now,
   output shared_mem_pkg::data_in mem_u_in,
   output shared_mem_pkg::data_in mem_l_in,
   input  logic                   mem_wait,
   input  logic [31:0]            mem_u_dout,
   input  logic [31:0]            mem_l_dout,
   output logic [31:0]            stall_cycles
);
   import shared_mem_pkg::*;

   if (ADDR_W != shared_mem_pkg::ADDR_W || READ_LATENCY < 1 || READ_LATENCY > 7) begin : g_bad_cfg
      $error("core_mem_port: ADDR_W must match shared_mem_pkg and READ_LATENCY must be 1..7");
   end

   localparam logic [2:0] LAT_INIT = 3'(READ_LATENCY - 1);

   mem_port_state_e state_q, state_d;
   data_in          u_q, u_d, l_q, l_d;
   logic            u_en_q, u_en_d, l_en_q, l_en_d;
   logic            load_q, load_d;
   logic [2:0]      cnt_q, cnt_d;
   logic [31:0]     rd_u_q, rd_u_d, rd_l_q, rd_l_d;
   logic            accept;

   always_comb begin
      state_d = state_q;
      u_d     = u_q;
      l_d     = l_q;
      u_en_d  = u_en_q;
      l_en_d  = l_en_q;
      load_d  = load_q;
      cnt_d   = cnt_q;
      rd_u_d  = rd_u_q;
      rd_l_d  = rd_l_q;
      accept  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid && (req_u_en || req_l_en)) begin
               accept   = 1'b1;
               u_d      = req_u;
               l_d      = req_l;
               u_d.we   = req_u.we & req_u_en;
               l_d.we   = req_l.we & req_l_en;
               u_en_d   = req_u_en;
               l_en_d   = req_l_en;
               load_d   = (req_u_en & ~req_u.we) | (req_l_en & ~req_l.we);
               state_d  = REQ;
            end
         end
         REQ: begin
            if (!mem_wait) begin
               if (!load_q) begin
                  state_d = IDLE;
               end else if (READ_LATENCY == 1) begin
                  state_d = DONE;
               end else begin
                  state_d = LAT;
                  cnt_d   = LAT_INIT;
               end
            end
         end
         // The counter reaches zero on the cycle DONE is entered, so DONE lands on grant+READ_LATENCY.
         LAT: begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd1) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (u_en_q) begin
               rd_u_d = mem_u_dout;
            end
            if (l_en_q) begin
               rd_l_d = mem_l_dout;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         u_q     <= '0;
         l_q     <= '0;
         u_en_q  <= 1'b0;
         l_en_q  <= 1'b0;
         load_q  <= 1'b0;
         cnt_q   <= 3'd0;
         rd_u_q  <= 32'd0;
         rd_l_q  <= 32'd0;
      end else begin
         state_q <= state_d;
         u_q     <= u_d;
         l_q     <= l_d;
         u_en_q  <= u_en_d;
         l_en_q  <= l_en_d;
         load_q  <= load_d;
         cnt_q   <= cnt_d;
         rd_u_q  <= rd_u_d;
         rd_l_q  <= rd_l_d;
      end
   end

   // Load data is presented in the DONE cycle itself and held by the register afterwards.
   assign interlock   = (state_q != IDLE) | accept;
   assign rd_valid    = (state_q == DONE);
   assign rd_u        = rd_u_d;
   assign rd_l        = rd_l_d;
   assign mem_req_now = (state_q == REQ);
   assign mem_u_in    = {u_q.addr, u_q.din, u_q.we & mem_req_now};
   assign mem_l_in    = {l_q.addr, l_q.din, l_q.we & mem_req_now};

`ifdef CORE_MEM_PORT_STALL_CNT_EN
   logic [31:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if (mem_req_now && mem_wait) begin
         stall_d = stall_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stall_q <= 32'd0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign stall_cycles = stall_q;
`else
   assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_core_mem_port.sv
// Bench for core_mem_port: directed accesses with literal expectations plus random traffic
// compared every cycle against a transaction model indexed by cycle number.
module tb_core_mem_port;
   import shared_mem_pkg::*;

   localparam int RL = 3;

   logic        clk, rstn, req_valid, req_u_en, req_l_en;
   logic        interlock, rd_valid, mem_req_now, mem_wait;
   data_in      req_u, req_l, mem_u_in, mem_l_in;
   logic [31:0] rd_u, rd_l, mem_u_dout, mem_l_dout, stall_cycles;

   int errors = 0;
   int checks = 0;

   core_mem_port #(.READ_LATENCY(RL)) dut (
      .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_u_en(req_u_en), .req_l_en(req_l_en),
      .req_u(req_u), .req_l(req_l), .interlock(interlock), .rd_valid(rd_valid),
      .rd_u(rd_u), .rd_l(rd_l), .mem_req_now(mem_req_now), .mem_u_in(mem_u_in),
      .mem_l_in(mem_l_in), .mem_wait(mem_wait), .mem_u_dout(mem_u_dout),
      .mem_l_dout(mem_l_dout), .stall_cycles(stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic data_in mk(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic w);
      data_in x;
      x.addr = a;
      x.din  = d;
      x.we   = w;
      return x;
   endfunction

   function automatic void checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
      end
   endfunction

   task automatic applyStimulus();
      req_valid  = ($urandom_range(0, 1) == 1);
      req_u_en   = 1'($urandom_range(0, 1));
      req_l_en   = 1'($urandom_range(0, 1));
      req_u      = mk(17'($urandom), $urandom, 1'($urandom_range(0, 1)));
      req_l      = mk(17'($urandom), $urandom, 1'($urandom_range(0, 1)));
      mem_wait   = ($urandom_range(0, 9) < 3);
      mem_u_dout = $urandom;
      mem_l_dout = $urandom;
   endtask

   // One access from its acceptance cycle until interlock drops; called at posedge+1 of an idle cycle.
   task automatic runAccess(input logic ue, input logic le, input data_in ru, input data_in rl,
                            input int waits, input logic [31:0] udout, input logic [31:0] ldout,
                            output int rdv_at, output int busy, output int req_cnt,
                            output int cmd_bad, output int lwe_seen);
      data_in exp_u, exp_l;
      exp_u = ru;
      exp_l = rl;
      exp_u.we = ru.we & ue;
      exp_l.we = rl.we & le;
      rdv_at = -1; busy = 0; req_cnt = 0; cmd_bad = 0; lwe_seen = 0;
      req_u_en = ue; req_l_en = le; req_u = ru; req_l = rl;
      mem_u_dout = udout; mem_l_dout = ldout;
      req_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (i > 0) begin
            @(posedge clk); #1;
            req_valid = 1'b0;
         end
         mem_wait = (i >= 1 && i <= waits);
         @(negedge clk);
         if (!interlock) break;
         busy++;
         if (rd_valid) rdv_at = i;
         if (mem_req_now) begin
            req_cnt++;
            if (mem_u_in !== exp_u || mem_l_in !== exp_l) cmd_bad++;
         end
         if (mem_l_in.we) lwe_seen++;
      end
      mem_wait = 1'b0;
      @(posedge clk); #1;
   endtask

   // Transaction model: an access is in flight from acceptance until its grant (store) or its data cycle (load).
   bit          m_act, m_granted, m_load, m_uen, m_len, m_was_act, e_req, e_rdv, e_int;
   data_in      m_u, m_l;
   logic [31:0] m_rd_u, m_rd_l, m_stall, e_rd_u, e_rd_l;
   int          m_cyc, m_done_at;

   always @(negedge clk) begin
      if (!rstn) begin
         m_act = 0; m_granted = 0; m_load = 0; m_uen = 0; m_len = 0;
         m_u = '0; m_l = '0; m_rd_u = 0; m_rd_l = 0; m_stall = 0;
         m_cyc = 0; m_done_at = 0;
      end else begin
         m_was_act = m_act;
         e_req  = m_act && !m_granted;
         e_rdv  = m_act && m_granted && (m_cyc == m_done_at);
         e_int  = m_act || (req_valid && (req_u_en || req_l_en));
         e_rd_u = (e_rdv && m_uen) ? mem_u_dout : m_rd_u;
         e_rd_l = (e_rdv && m_len) ? mem_l_dout : m_rd_l;
         checkOutput("interlock", 64'(interlock), 64'(e_int));
         checkOutput("rd_valid", 64'(rd_valid), 64'(e_rdv));
         checkOutput("rd_u", 64'(rd_u), 64'(e_rd_u));
         checkOutput("rd_l", 64'(rd_l), 64'(e_rd_l));
         checkOutput("mem_req_now", 64'(mem_req_now), 64'(e_req));
         checkOutput("mem_u_in", 64'(mem_u_in), 64'({m_u.addr, m_u.din, m_u.we & e_req}));
         checkOutput("mem_l_in", 64'(mem_l_in), 64'({m_l.addr, m_l.din, m_l.we & e_req}));
         checkOutput("stall_cycles", 64'(stall_cycles), 64'(m_stall));
         if (e_req && !mem_wait) begin
            m_granted = 1;
            m_done_at = m_cyc + RL;
            if (!m_load) m_act = 0;
         end
`ifdef CORE_MEM_PORT_STALL_CNT_EN
         if (e_req && mem_wait) m_stall = m_stall + 32'd1;
`endif
         if (e_rdv) begin
            m_rd_u = e_rd_u;
            m_rd_l = e_rd_l;
            m_act  = 0;
         end
         if (!m_was_act && req_valid && (req_u_en || req_l_en)) begin
            m_act = 1; m_granted = 0;
            m_uen = req_u_en; m_len = req_l_en;
            m_u = req_u; m_l = req_l;
            m_u.we = req_u.we & req_u_en;
            m_l.we = req_l.we & req_l_en;
            m_load = (req_u_en && !req_u.we) || (req_l_en && !req_l.we);
         end
         m_cyc++;
      end
   end

   int rdv_at, busy, req_cnt, cmd_bad, lwe_seen;
   int rise1, rise2, first_rdv;
   bit prev_req;

   initial begin
      rstn = 1'b0; req_valid = 1'b0; req_u_en = 1'b0; req_l_en = 1'b0;
      req_u = '0; req_l = '0; mem_wait = 1'b0; mem_u_dout = '0; mem_l_dout = '0;
      #3;
      checkOutput("reset_interlock", 64'(interlock), 64'd0);
      checkOutput("reset_mem_req_now", 64'(mem_req_now), 64'd0);
      checkOutput("reset_rd_u", 64'(rd_u), 64'd0);
      checkOutput("reset_mem_u_in", 64'(mem_u_in), 64'd0);
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;

      // Upper-lane load, no stall.
      runAccess(1'b1, 1'b0, mk(17'h10, 32'h0, 1'b0), mk(17'h0, 32'h0, 1'b0), 0,
                32'hDEADBEEF, 32'h0, rdv_at, busy, req_cnt, cmd_bad, lwe_seen);
      checkOutput("t1_rdv_at", 64'(rdv_at), 64'(RL + 1));
      checkOutput("t1_busy", 64'(busy), 64'(RL + 2));
      checkOutput("t1_req_cnt", 64'(req_cnt), 64'd1);
      @(negedge clk);
      checkOutput("t1_rd_u", 64'(rd_u), 64'hDEADBEEF);
      checkOutput("t1_rd_l", 64'(rd_l), 64'd0);
      @(posedge clk); #1;

      // Two-lane store with three arbitration stalls.
      runAccess(1'b1, 1'b1, mk(17'h20, 32'h1, 1'b1), mk(17'h21, 32'h2, 1'b1), 3,
                32'h0, 32'h0, rdv_at, busy, req_cnt, cmd_bad, lwe_seen);
      checkOutput("t2_rdv_at", 64'(rdv_at), -64'sd1);
      checkOutput("t2_busy", 64'(busy), 64'd5);
      checkOutput("t2_req_cnt", 64'(req_cnt), 64'd4);
      checkOutput("t2_cmd_stable", 64'(cmd_bad), 64'd0);
      @(negedge clk);
`ifdef CORE_MEM_PORT_STALL_CNT_EN
      checkOutput("t2_stall_cycles", 64'(stall_cycles), 64'd3);
`else
      checkOutput("t2_stall_cycles", 64'(stall_cycles), 64'd0);
`endif
      checkOutput("t2_mem_u_in_we", 64'(mem_u_in.we), 64'd0);
      @(posedge clk); #1;

      // Both-lane load, then upper-only load: lower read data must survive.
      runAccess(1'b1, 1'b1, mk(17'h30, 32'h0, 1'b0), mk(17'h31, 32'h0, 1'b0), 1,
                32'hAAAA0001, 32'hBBBB0002, rdv_at, busy, req_cnt, cmd_bad, lwe_seen);
      checkOutput("t3a_rdv_at", 64'(rdv_at), 64'(RL + 2));
      runAccess(1'b1, 1'b0, mk(17'h32, 32'h0, 1'b0), mk(17'h33, 32'h77, 1'b1), 0,
                32'h12345678, 32'h55, rdv_at, busy, req_cnt, cmd_bad, lwe_seen);
      checkOutput("t3b_rdv_at", 64'(rdv_at), 64'(RL + 1));
      checkOutput("t3b_l_we_seen", 64'(lwe_seen), 64'd0);
      @(negedge clk);
      checkOutput("t3b_rd_u", 64'(rd_u), 64'h12345678);
      checkOutput("t3b_rd_l", 64'(rd_l), 64'hBBBB0002);
      @(posedge clk); #1;

      // Reset while the load is waiting out its latency.
      req_u_en = 1'b1; req_l_en = 1'b1;
      req_u = mk(17'h50, 32'h0, 1'b0); req_l = mk(17'h51, 32'h0, 1'b0);
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      #2 rstn = 1'b0;
      #1;
      checkOutput("rst_interlock", 64'(interlock), 64'd0);
      checkOutput("rst_rd_valid", 64'(rd_valid), 64'd0);
      checkOutput("rst_rd_u", 64'(rd_u), 64'd0);
      checkOutput("rst_rd_l", 64'(rd_l), 64'd0);
      checkOutput("rst_mem_req_now", 64'(mem_req_now), 64'd0);
      checkOutput("rst_mem_u_in", 64'(mem_u_in), 64'd0);
      checkOutput("rst_mem_l_in", 64'(mem_l_in), 64'd0);
      checkOutput("rst_stall_cycles", 64'(stall_cycles), 64'd0);
      @(posedge clk); #1;
      rstn = 1'b1;
      repeat (RL + 2) begin
         @(negedge clk);
         checkOutput("rst_no_rd_valid", 64'(rd_valid), 64'd0);
      end
      @(posedge clk); #1;
      runAccess(1'b0, 1'b1, mk(17'h0, 32'h0, 1'b0), mk(17'h60, 32'h0, 1'b0), 0,
                32'h0, 32'h600DF00D, rdv_at, busy, req_cnt, cmd_bad, lwe_seen);
      checkOutput("rst_post_rdv_at", 64'(rdv_at), 64'(RL + 1));
      @(negedge clk);
      checkOutput("rst_post_rd_l", 64'(rd_l), 64'h600DF00D);
      @(posedge clk); #1;

      // Back-to-back loads with req_valid held high.
      req_u_en = 1'b1; req_l_en = 1'b0;
      req_u = mk(17'h40, 32'h0, 1'b0); req_l = '0;
      mem_u_dout = 32'hCAFE0001; mem_wait = 1'b0; req_valid = 1'b1;
      rise1 = -1; rise2 = -1; first_rdv = -1; prev_req = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (i > 0) begin
            @(posedge clk); #1;
         end
         @(negedge clk);
         if (mem_req_now && !prev_req) begin
            if (rise1 < 0) rise1 = i;
            else if (rise2 < 0) rise2 = i;
         end
         if (rd_valid && first_rdv < 0) first_rdv = i;
         prev_req = mem_req_now;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      checkOutput("b2b_first_rise", 64'(rise1), 64'd1);
      checkOutput("b2b_first_rdv", 64'(first_rdv), 64'(RL + 1));
      checkOutput("b2b_spacing", 64'(rise2 - rise1), 64'(RL + 2));

      repeat (3000) begin
         @(posedge clk); #1;
         applyStimulus();
      end
      @(posedge clk); #1;
      req_valid = 1'b0; mem_wait = 1'b0;
      repeat (12) @(posedge clk);
      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
